// File: rtl/spi_square_draw_pkg.sv
// Shared constants and types for the SPI rectangle drawer (ILI9341 command set).
package spi_square_draw_pkg;

    localparam int         RGB_W     = 16;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef logic [RGB_W-1:0] rgb565_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CASET, S_PASET, S_RAMWR, S_PIXEL, S_DONE
    } state_t;

    function automatic logic on_edge(input logic [15:0] cx, cy, x0, x1, y0, y1);
        return (cx == x0) || (cx == x1) || (cy == y0) || (cy == y1);
    endfunction

endpackage

// File: rtl/spi_square_draw_if.sv
// Request/SPI-side signal bundle of the rectangle drawer.
interface spi_square_draw_if;
    logic        i_start;
    logic [15:0] i_x, i_y, i_w, i_h;
    logic [15:0] i_color, i_fill;
    logic        o_mosi, o_dc, o_cs, o_busy, o_done;

    modport master (output i_start, i_x, i_y, i_w, i_h, i_color, i_fill,
                    input  o_mosi, o_dc, o_cs, o_busy, o_done);
    modport slave  (input  i_start, i_x, i_y, i_w, i_h, i_color, i_fill,
                    output o_mosi, o_dc, o_cs, o_busy, o_done);
endinterface

// File: rtl/spi_square_draw_byte_tx.sv
// 8-bit MSB-first shifter; a load on the last-bit cycle continues seamlessly into the next byte.
module spi_byte_tx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dc_in,
    output logic       mosi,
    output logic       dc,
    output logic       last
);
    logic [7:0] sh;
    logic [2:0] cnt;
    logic       act;
    logic       dc_r;

    // Zeros shift in behind the data so mosi idles low once a byte drains.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sh   <= '0;
            cnt  <= '0;
            act  <= 1'b0;
            dc_r <= 1'b0;
        end else if (load) begin
            sh   <= data;
            cnt  <= '0;
            act  <= 1'b1;
            dc_r <= dc_in;
        end else if (act) begin
            sh  <= {sh[6:0], 1'b0};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                act  <= 1'b0;
                dc_r <= 1'b0;
            end
        end
    end

    assign mosi = sh[7];
    assign dc   = dc_r;
    assign last = act && (cnt == 3'd7);
endmodule

// File: rtl/spi_square_draw.sv
// Draws a clipped solid RGB565 rectangle: CASET, PASET, RAMWR, then pixel data, one bit per clock.
// Build option: SQUARE_BORDER_EN paints the outline with i_color and the interior with i_fill.
module spi_square_draw
    import spi_square_draw_pkg::*;
#(
    parameter int DELAY  = 20,
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_square_draw_if.slave  bus
);
    localparam logic [16:0] X_MAX = 17'(WIDTH - 1);
    localparam logic [16:0] Y_MAX = 17'(HEIGHT - 1);

    state_t      st;
    logic [2:0]  idx;
    logic [15:0] dly_cnt;
    logic [15:0] x0, y0, x1, y1, cx, cy;
    rgb565_t     color_r, pix_col, cur_col;
    logic        last_pix, cs_r, busy_r, done_r;

    logic        ld, fin, ld_dc, tx_last;
    state_t      ld_st;
    logic [2:0]  ld_idx;
    logic [7:0]  ld_byte;

    // Clip against the panel in 17 bits so x0+w cannot wrap.
    logic [16:0] x_end, y_end;
    logic [15:0] x1_in, y1_in;
    logic        empty_in;
    assign x_end    = {1'b0, bus.i_x} + {1'b0, bus.i_w} - 17'd1;
    assign y_end    = {1'b0, bus.i_y} + {1'b0, bus.i_h} - 17'd1;
    assign x1_in    = (x_end > X_MAX) ? X_MAX[15:0] : x_end[15:0];
    assign y1_in    = (y_end > Y_MAX) ? Y_MAX[15:0] : y_end[15:0];
    assign empty_in = (bus.i_w == 16'd0) || (bus.i_h == 16'd0) ||
                      ({1'b0, bus.i_x} > X_MAX) || ({1'b0, bus.i_y} > Y_MAX);

`ifdef SQUARE_BORDER_EN
    rgb565_t fill_r;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                         fill_r <= '0;
        else if (st == S_IDLE && bus.i_start) fill_r <= bus.i_fill;
    end
    assign cur_col = on_edge(cx, cy, x0, x1, y0, y1) ? color_r : fill_r;
`else
    logic unused_fill;
    assign unused_fill = ^bus.i_fill;
    assign cur_col     = color_r;
`endif

    // Next byte to load: (state, idx) names the byte currently on the wire.
    always_comb begin
        ld     = 1'b0;
        fin    = 1'b0;
        ld_st  = st;
        ld_idx = idx;
        case (st)
            S_WAIT:  if (dly_cnt == 16'd0) begin ld = 1'b1; ld_st = S_CASET; ld_idx = 3'd0; end
            S_CASET: if (tx_last) begin
                ld = 1'b1;
                if (idx == 3'd4) begin ld_st = S_PASET; ld_idx = 3'd0; end
                else ld_idx = idx + 3'd1;
            end
            S_PASET: if (tx_last) begin
                ld = 1'b1;
                if (idx == 3'd4) begin ld_st = S_RAMWR; ld_idx = 3'd0; end
                else ld_idx = idx + 3'd1;
            end
            S_RAMWR: if (tx_last) begin ld = 1'b1; ld_st = S_PIXEL; ld_idx = 3'd0; end
            S_PIXEL: if (tx_last) begin
                if (idx == 3'd0)   begin ld = 1'b1; ld_idx = 3'd1; end
                else if (last_pix) fin = 1'b1;
                else               begin ld = 1'b1; ld_idx = 3'd0; end
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        ld_dc   = 1'b1;
        case (ld_st)
            S_CASET: case (ld_idx)
                3'd0:    begin ld_byte = CMD_CASET; ld_dc = 1'b0; end
                3'd1:    ld_byte = x0[15:8];
                3'd2:    ld_byte = x0[7:0];
                3'd3:    ld_byte = x1[15:8];
                default: ld_byte = x1[7:0];
            endcase
            S_PASET: case (ld_idx)
                3'd0:    begin ld_byte = CMD_PASET; ld_dc = 1'b0; end
                3'd1:    ld_byte = y0[15:8];
                3'd2:    ld_byte = y0[7:0];
                3'd3:    ld_byte = y1[15:8];
                default: ld_byte = y1[7:0];
            endcase
            S_RAMWR: begin ld_byte = CMD_RAMWR; ld_dc = 1'b0; end
            S_PIXEL: ld_byte = (ld_idx == 3'd0) ? cur_col[15:8] : pix_col[7:0];
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            st       <= S_IDLE;
            idx      <= '0;
            dly_cnt  <= '0;
            x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0; cx <= '0; cy <= '0;
            color_r  <= '0;
            pix_col  <= '0;
            last_pix <= 1'b0;
            cs_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (st)
                S_IDLE: if (bus.i_start) begin
                    x0 <= bus.i_x;  y0 <= bus.i_y;
                    x1 <= x1_in;    y1 <= y1_in;
                    cx <= bus.i_x;  cy <= bus.i_y;
                    color_r  <= bus.i_color;
                    last_pix <= 1'b0;
                    busy_r   <= 1'b1;
                    if (empty_in) begin
                        st     <= S_DONE;
                        done_r <= 1'b1;
                    end else begin
                        st      <= S_WAIT;
                        dly_cnt <= 16'(DELAY - 1);
                    end
                end
                S_WAIT: if (dly_cnt != 16'd0) dly_cnt <= dly_cnt - 16'd1;
                S_DONE: begin
                    st     <= S_IDLE;
                    busy_r <= 1'b0;
                end
                default: ;
            endcase

            if (ld) begin
                st   <= ld_st;
                idx  <= ld_idx;
                cs_r <= 1'b0;
            end
            // Low byte load retires the pixel and steps the raster position.
            if (ld && ld_st == S_PIXEL) begin
                if (ld_idx == 3'd0) pix_col <= cur_col;
                else begin
                    last_pix <= (cx == x1) && (cy == y1);
                    if (cx == x1) begin
                        cx <= x0;
                        cy <= cy + 16'd1;
                    end else cx <= cx + 16'd1;
                end
            end
            if (fin) begin
                st     <= S_DONE;
                cs_r   <= 1'b1;
                done_r <= 1'b1;
            end
        end
    end

    spi_byte_tx u_tx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .load  (ld),
        .data  (ld_byte),
        .dc_in (ld_dc),
        .mosi  (bus.o_mosi),
        .dc    (bus.o_dc),
        .last  (tx_last)
    );

    assign bus.o_cs   = cs_r;
    assign bus.o_busy = busy_r;
    assign bus.o_done = done_r;
endmodule

// File: tb/tb_spi_square_draw.sv
// Directed bench for spi_square_draw on a 24x32 panel with DELAY=20.
module tb_spi_square_draw;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    spi_square_draw_if bus ();
    spi_square_draw #(.DELAY(20), .WIDTH(24), .HEIGHT(32)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    // Bus monitor: bytes shifted while CS is low, plus pulse/level counters.
    int         cs_low_cnt, done_cnt, busy_cnt, bitn, cyc, acc_cyc, cs_cyc;
    bit         dc_bad;
    logic       dc_first;
    logic [7:0] shb;
    logic [7:0] q_byte[$];
    logic       q_dc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.o_busy) begin
                if (busy_cnt == 0) acc_cyc = cyc;
                busy_cnt++;
            end
            if (bus.o_done) done_cnt++;
            if (!bus.o_cs) begin
                if (cs_low_cnt == 0) cs_cyc = cyc;
                cs_low_cnt++;
                if (bitn == 0) dc_first = bus.o_dc;
                else if (bus.o_dc !== dc_first) dc_bad = 1'b1;
                shb = {shb[6:0], bus.o_mosi};
                bitn++;
                if (bitn == 8) begin
                    q_byte.push_back(shb);
                    q_dc.push_back(dc_first);
                    bitn = 0;
                end
            end
        end
    end

    task automatic clear_mon();
        cs_low_cnt = 0; done_cnt = 0; busy_cnt = 0; bitn = 0;
        acc_cyc = 0; cs_cyc = 0; dc_bad = 1'b0;
        q_byte.delete(); q_dc.delete();
    endtask

    task automatic do_start(input logic [15:0] x, y, w, h, c, f);
        @(negedge clk);
        bus.i_x = x; bus.i_y = y; bus.i_w = w; bus.i_h = h;
        bus.i_color = c; bus.i_fill = f;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        got = (done_cnt != 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_cs_low(input int target, input int budget, output bit got);
        int n = 0;
        while (cs_low_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        got = (cs_low_cnt >= target);
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_x = '0; bus.i_y = '0; bus.i_w = '0; bus.i_h = '0;
        bus.i_color = '0; bus.i_fill = '0;
        #23;
        tests++; if (bus.o_cs !== 1'b1)   begin fails++; $display("FAIL reset_cs: got %b want 1", bus.o_cs); end
        tests++; if (bus.o_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", bus.o_mosi); end
        tests++; if (bus.o_dc !== 1'b0)   begin fails++; $display("FAIL reset_dc: got %b want 0", bus.o_dc); end
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.o_cs !== 1'b1) begin fails++; $display("FAIL idle_cs: got %b want 1", bus.o_cs); end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        int bad;
        bit got;
        exp = {8'h2A, 8'h00, 8'h02, 8'h00, 8'h05, 8'h2B, 8'h00, 8'h03, 8'h00, 8'h04, 8'h2C};
        for (int i = 0; i < 8; i++) begin exp.push_back(8'hF8); exp.push_back(8'h00); end
        clear_mon();
        do_start(16'd2, 16'd3, 16'd4, 16'd2, 16'hF800, 16'h0000);
        wait_done(2000, got);
        tests++; if (!got) begin fails++; $display("FAIL basic_timeout: got no o_done, want one"); end
        bad = -1;
        if (q_byte.size() != exp.size()) bad = q_byte.size();
        else foreach (exp[i]) if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL basic_bytes: got %0d bytes (diff at %0d) want %0d", q_byte.size(), bad, exp.size()); end
        bad = -1;
        foreach (q_dc[i]) if (bad < 0 && q_dc[i] !== !(i == 0 || i == 5 || i == 10)) bad = i;
        tests++; if (bad >= 0 || dc_bad) begin fails++; $display("FAIL basic_dc: got bad byte %0d split %0b want none", bad, dc_bad); end
        tests++; if (cs_low_cnt != 216) begin fails++; $display("FAIL basic_cs_low: got %0d want 216", cs_low_cnt); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        tests++; if (cs_cyc - acc_cyc != 20) begin fails++; $display("FAIL basic_delay: got %0d want 20", cs_cyc - acc_cyc); end
        tests++; if (busy_cnt != 237) begin fails++; $display("FAIL basic_busy: got %0d want 237", busy_cnt); end
        tests++; if (bus.o_busy !== 1'b0 || bus.o_cs !== 1'b1) begin fails++; $display("FAIL basic_idle: got busy %b cs %b want 0 1", bus.o_busy, bus.o_cs); end
    endtask

    task automatic test_clip();
        logic [7:0] exp[$];
        int bad;
        bit got;
        exp = {8'h2A, 8'h00, 8'h14, 8'h00, 8'h17, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
        for (int i = 0; i < 4; i++) begin exp.push_back(8'h07); exp.push_back(8'hE0); end
        clear_mon();
        do_start(16'd20, 16'd0, 16'd10, 16'd1, 16'h07E0, 16'h0000);
        wait_done(2000, got);
        tests++; if (!got) begin fails++; $display("FAIL clip_timeout: got no o_done, want one"); end
        bad = -1;
        if (q_byte.size() != exp.size()) bad = q_byte.size();
        else foreach (exp[i]) if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL clip_bytes: got %0d bytes (diff at %0d) want %0d", q_byte.size(), bad, exp.size()); end
        tests++; if (cs_low_cnt != 152) begin fails++; $display("FAIL clip_cs_low: got %0d want 152", cs_low_cnt); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL clip_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty();
        clear_mon();
        do_start(16'd1, 16'd1, 16'd0, 16'd5, 16'hFFFF, 16'h0000);
        tests++; if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1) begin fails++; $display("FAIL empty_w_pulse: got done %b busy %b want 1 1", bus.o_done, bus.o_busy); end
        repeat (5) @(negedge clk);
        tests++; if (done_cnt != 1 || busy_cnt != 1) begin fails++; $display("FAIL empty_w_counts: got done %0d busy %0d want 1 1", done_cnt, busy_cnt); end
        tests++; if (cs_low_cnt != 0) begin fails++; $display("FAIL empty_w_cs: got %0d low cycles want 0", cs_low_cnt); end
        clear_mon();
        do_start(16'd24, 16'd0, 16'd3, 16'd3, 16'hFFFF, 16'h0000);
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL empty_x_pulse: got %b want 1", bus.o_done); end
        repeat (5) @(negedge clk);
        tests++; if (done_cnt != 1 || cs_low_cnt != 0) begin fails++; $display("FAIL empty_x_counts: got done %0d cs_low %0d want 1 0", done_cnt, cs_low_cnt); end
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_mon();
        do_start(16'd2, 16'd3, 16'd4, 16'd2, 16'hF800, 16'h0000);
        wait_cs_low(120, 1000, got);
        tests++; if (!got) begin fails++; $display("FAIL rstmid_reach: got %0d low cycles want 120", cs_low_cnt); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.o_cs !== 1'b1 || bus.o_mosi !== 1'b0 || bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_abort: got cs %b mosi %b busy %b want 1 0 0", bus.o_cs, bus.o_mosi, bus.o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        do_start(16'd2, 16'd3, 16'd4, 16'd2, 16'hF800, 16'h0000);
        wait_done(2000, got);
        tests++; if (!got || cs_low_cnt != 216 || q_byte.size() != 27) begin
            fails++; $display("FAIL rstmid_rerun: got done %0b cs_low %0d bytes %0d want 1 216 27", got, cs_low_cnt, q_byte.size());
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] exp[$];
        int bad;
        bit got;
        exp = {8'h2A, 8'h00, 8'h02, 8'h00, 8'h05, 8'h2B, 8'h00, 8'h03, 8'h00, 8'h04, 8'h2C};
        for (int i = 0; i < 8; i++) begin exp.push_back(8'hF8); exp.push_back(8'h00); end
        clear_mon();
        do_start(16'd2, 16'd3, 16'd4, 16'd2, 16'hF800, 16'h0000);
        wait_cs_low(130, 1000, got);
        do_start(16'd0, 16'd0, 16'd1, 16'd1, 16'h1234, 16'h0000);
        wait_done(2000, got);
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL ignore_done_cnt: got %0d want 1", done_cnt); end
        bad = -1;
        if (q_byte.size() != exp.size()) bad = q_byte.size();
        else foreach (exp[i]) if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
        tests++; if (bad >= 0 || cs_low_cnt != 216) begin fails++; $display("FAIL ignore_stream: got diff at %0d cs_low %0d want none 216", bad, cs_low_cnt); end
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL ignore_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_border();
        logic [7:0] exp[$];
        int bad;
        bit got;
        exp = {8'h2A, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C};
        for (int i = 0; i < 9; i++) begin
`ifdef SQUARE_BORDER_EN
            if (i == 4) begin exp.push_back(8'h00); exp.push_back(8'h1F); end
            else        begin exp.push_back(8'hFF); exp.push_back(8'hFF); end
`else
            exp.push_back(8'hFF); exp.push_back(8'hFF);
`endif
        end
        clear_mon();
        do_start(16'd0, 16'd0, 16'd3, 16'd3, 16'hFFFF, 16'h001F);
        wait_done(2000, got);
        bad = -1;
        if (q_byte.size() != exp.size()) bad = q_byte.size();
        else foreach (exp[i]) if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL border_bytes: got %0d bytes (diff at %0d) want %0d", q_byte.size(), bad, exp.size()); end
        tests++; if (cs_low_cnt != 232 || done_cnt != 1) begin fails++; $display("FAIL border_frame: got cs_low %0d done %0d want 232 1", cs_low_cnt, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_reset_mid();
        test_ignore_start();
        test_border();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
